// File: rtl/uart_rx_4x.sv
// UART receiver driven by a 4x-baud tick: 2-flop input synchroniser, mid-bit sampling,
// 1 start / DATA_BITS data (LSB first) / 1 stop, with registered valid and framing-error strobes.
module uart_rx_4x #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clock_in,
  input  logic                 n_reset_in,
  input  logic                 tick_in,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 framing_error_out,
  output logic                 busy_out
);

  // state      | meaning
  // IDLE       | line idle, waiting for rx_s low on a tick
  // START      | start edge seen, confirm at mid start bit (T2)
  // DATA       | sample one data bit every 4 ticks
  // STOP       | sample stop bit, emit valid or framing error
  // BREAK_WAIT | stop bit was low, wait for the line to return high
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } state_t;

  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic [1:0]           phase_q, phase_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    sync1_d   = rx_in;
    sync2_d   = sync1_q;
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    if (tick_in) begin
      phase_d = phase_q + 2'd1;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            phase_d = 2'd0;
          end
        end
        START: begin
          // Re-zero the phase at T2 so every later sample lands on phase 3 (T6, T10, ...).
          if (phase_q == 2'd1) begin
            phase_d = 2'd0;
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end
          end
        end
        DATA: begin
          if (phase_q == 2'd3) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
        end
        STOP: begin
          if (phase_q == 2'd3) begin
            if (rx_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK_WAIT;
            end
          end
        end
        BREAK_WAIT: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      phase_q   <= 2'd0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign data_out          = data_q;
  assign valid_out         = valid_q;
  assign framing_error_out = ferr_q;
  assign busy_out          = busy_q;

endmodule

// File: tb/tb_uart_rx_4x.sv
// Directed bench for uart_rx_4x: an 8-bit and a 7-bit instance share clock, reset and tick;
// expected words, strobe counts and tick positions are written out by hand per scenario.
module tb_uart_rx_4x;

  logic       clock_in;
  logic       n_reset_in;
  logic       tick_in;
  logic       rx_in;
  logic       rx7;
  logic [7:0] data_out;
  logic       valid_out, framing_error_out, busy_out;
  logic [6:0] data7;
  logic       valid7, ferr7, busy7;

  int n_checks = 0;
  int n_fail   = 0;
  int tick_period = 3;
  int tick_cnt = 0;

  int         v_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int         v7_cnt = 0, fe7_cnt = 0;
  logic [7:0] v_q[$];

  uart_rx_4x #(.DATA_BITS(8)) dut (
    .clock_in(clock_in), .n_reset_in(n_reset_in), .tick_in(tick_in), .rx_in(rx_in),
    .data_out(data_out), .valid_out(valid_out), .framing_error_out(framing_error_out),
    .busy_out(busy_out)
  );

  uart_rx_4x #(.DATA_BITS(7)) dut7 (
    .clock_in(clock_in), .n_reset_in(n_reset_in), .tick_in(tick_in), .rx_in(rx7),
    .data_out(data7), .valid_out(valid7), .framing_error_out(ferr7), .busy_out(busy7)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Tick generator: one-clock pulse every tick_period clocks, changing 1 time unit after the edge.
  initial begin
    tick_in = 1'b0;
    forever begin
      @(posedge clock_in);
      #1;
      tick_cnt++;
      if (tick_cnt >= tick_period) begin
        tick_in  = 1'b1;
        tick_cnt = 0;
      end else begin
        tick_in = 1'b0;
      end
    end
  end

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clock_in) begin
    if (valid_out) begin
      v_cnt++;
      v_q.push_back(data_out);
    end
    if (framing_error_out) fe_cnt++;
    if (valid_out && framing_error_out) both_cnt++;
    if (valid7 || ferr7) begin
      if (valid7) v7_cnt++;
      if (ferr7) fe7_cnt++;
      if (valid7 && ferr7) both_cnt++;
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock_in);
      while (!tick_in) @(posedge clock_in);
    end
  endtask

  task automatic drive(input logic v, input bit to7);
    if (to7) rx7 = v;
    else     rx_in = v;
  endtask

  // Caller must be aligned just after a tick edge; returns just after the 4th tick of the stop bit.
  task automatic send_frame(input logic [7:0] d, input int nbits, input logic stop_bit);
    #2 drive(1'b0, 1'b0);
    wait_ticks(4);
    for (int i = 0; i < nbits; i++) begin
      #2 drive(d[i], 1'b0);
      wait_ticks(4);
    end
    #2 drive(stop_bit, 1'b0);
    wait_ticks(4);
  endtask

  // Tick-accurate frame: checks that valid appears exactly after T(6+4*nbits).
  task automatic timed_frame(input logic [7:0] d, input int nbits, input bit to7);
    int   last;
    int   k;
    int   v0;
    logic v, b;
    logic [7:0] dv;
    last = 6 + 4 * nbits;
    v0 = to7 ? v7_cnt : v_cnt;
    #2 drive(1'b0, to7);
    for (int n = 0; n <= last; n++) begin
      wait_ticks(1);
      #1;
      v  = to7 ? valid7 : valid_out;
      b  = to7 ? busy7 : busy_out;
      dv = to7 ? {1'b0, data7} : data_out;
      if (n == 0) begin
        n_checks++;
        if (b !== 1'b1) begin n_fail++; $display("FAIL busy_rise_T0 nbits=%0d: busy=%b want 1", nbits, b); end
      end
      if (n == last - 1) begin
        n_checks++;
        if (v !== 1'b0 || b !== 1'b1) begin
          n_fail++; $display("FAIL pre_stop nbits=%0d: valid=%b busy=%b want 0,1", nbits, v, b);
        end
      end
      if (n == last) begin
        n_checks++;
        if (v !== 1'b1) begin n_fail++; $display("FAIL valid_at_T%0d: valid=%b want 1", last, v); end
        n_checks++;
        if (dv !== d) begin n_fail++; $display("FAIL data_at_T%0d: data=%h want %h", last, dv, d); end
        n_checks++;
        if (b !== 1'b0) begin n_fail++; $display("FAIL busy_fall_T%0d: busy=%b want 0", last, b); end
      end
      #1;
      if (((n - 3) % 4 == 0) && n >= 3 && n <= 3 + 4 * nbits) begin
        k = (n - 3) / 4;
        if (k < nbits) drive(d[k], to7);
        else           drive(1'b1, to7);
      end
    end
    @(posedge clock_in); #1;
    v = to7 ? valid7 : valid_out;
    n_checks++;
    if (v !== 1'b0) begin n_fail++; $display("FAIL valid_width nbits=%0d: valid=%b want 0", nbits, v); end
    repeat (6) @(posedge clock_in);
    n_checks++;
    if ((to7 ? v7_cnt : v_cnt) - v0 !== 1) begin
      n_fail++; $display("FAIL valid_pulse_count nbits=%0d: got %0d want 1", nbits, (to7 ? v7_cnt : v_cnt) - v0);
    end
  endtask

  task automatic test_reset;
    n_reset_in = 1'b0;
    rx_in = 1'b1;
    rx7 = 1'b1;
    #25;
    n_checks++;
    if ({data_out, valid_out, framing_error_out, busy_out} !== 11'd0) begin
      n_fail++; $display("FAIL reset_outputs: data=%h v=%b fe=%b busy=%b want all 0", data_out, valid_out, framing_error_out, busy_out);
    end
    n_checks++;
    if ({data7, valid7, ferr7, busy7} !== 10'd0) begin
      n_fail++; $display("FAIL reset_outputs7: data=%h v=%b fe=%b busy=%b want all 0", data7, valid7, ferr7, busy7);
    end
    @(negedge clock_in);
    n_reset_in = 1'b1;
    wait_ticks(3);
  endtask

  task automatic test_good_frame;
    int fe0;
    fe0 = fe_cnt;
    timed_frame(8'hA5, 8, 1'b0);
    n_checks++;
    if (fe_cnt !== fe0) begin n_fail++; $display("FAIL good_no_ferr: fe pulses=%0d want 0", fe_cnt - fe0); end
    wait_ticks(2);
  endtask

  task automatic test_false_start;
    int v0, fe0;
    v0 = v_cnt; fe0 = fe_cnt;
    #2 drive(1'b0, 1'b0);
    wait_ticks(1);
    #1;
    n_checks++;
    if (busy_out !== 1'b1) begin n_fail++; $display("FAIL false_start_busy_hi: busy=%b want 1", busy_out); end
    #1 drive(1'b1, 1'b0);
    wait_ticks(3);
    #1;
    n_checks++;
    if (busy_out !== 1'b0) begin n_fail++; $display("FAIL false_start_busy_lo: busy=%b want 0", busy_out); end
    wait_ticks(8);
    n_checks++;
    if (v_cnt !== v0 || fe_cnt !== fe0) begin
      n_fail++; $display("FAIL false_start_strobes: valid=%0d fe=%0d want 0,0", v_cnt - v0, fe_cnt - fe0);
    end
    n_checks++;
    if (data_out !== 8'hA5) begin n_fail++; $display("FAIL false_start_data: data=%h want a5", data_out); end
  endtask

  task automatic test_framing_error;
    int v0, fe0;
    v0 = v_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 8, 1'b0);
    wait_ticks(20);
    n_checks++;
    if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL ferr_pulse: cycles=%0d want 1", fe_cnt - fe0); end
    n_checks++;
    if (data_out !== 8'hA5) begin n_fail++; $display("FAIL ferr_data_kept: data=%h want a5", data_out); end
    n_checks++;
    if (busy_out !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_held: busy=%b want 1", busy_out); end
    #2 drive(1'b1, 1'b0);
    wait_ticks(12);
    #1;
    n_checks++;
    if (busy_out !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release: busy=%b want 0", busy_out); end
    n_checks++;
    if (v_cnt !== v0 || fe_cnt - fe0 !== 1) begin
      n_fail++; $display("FAIL ferr_no_more_strobes: valid=%0d fe=%0d want 0,1", v_cnt - v0, fe_cnt - fe0);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h00; exp_d[1] = 8'hFF; exp_d[2] = 8'h81;
    v_q.delete();
    for (int i = 0; i < 3; i++) send_frame(exp_d[i], 8, 1'b1);
    wait_ticks(6);
    n_checks++;
    if (v_q.size() !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", v_q.size()); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= v_q.size()) begin
        n_fail++; $display("FAIL b2b_word%0d: missing want %h", i, exp_d[i]);
      end else if (v_q[i] !== exp_d[i]) begin
        n_fail++; $display("FAIL b2b_word%0d: got %h want %h", i, v_q[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_fast_ticks;
    tick_period = 1;
    wait_ticks(4);
    v_q.delete();
    send_frame(8'h6B, 8, 1'b1);
    wait_ticks(8);
    n_checks++;
    if (v_q.size() !== 1 || (v_q.size() > 0 && v_q[0] !== 8'h6B)) begin
      n_fail++; $display("FAIL fast_tick_frame: count=%0d data=%h want 1,6b", v_q.size(), data_out);
    end
    tick_period = 3;
    wait_ticks(3);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    d = 8'h55;
    v_q.delete();
    #2 drive(1'b0, 1'b0);
    wait_ticks(4);
    for (int i = 0; i < 3; i++) begin
      #2 drive(d[i], 1'b0);
      wait_ticks(4);
    end
    #2 drive(d[3], 1'b0);
    wait_ticks(2);
    #3 n_reset_in = 1'b0;
    #1;
    n_checks++;
    if ({data_out, valid_out, framing_error_out, busy_out} !== 11'd0) begin
      n_fail++; $display("FAIL reset_mid_async: data=%h v=%b fe=%b busy=%b want all 0", data_out, valid_out, framing_error_out, busy_out);
    end
    drive(1'b1, 1'b0);
    repeat (4) @(posedge clock_in);
    @(negedge clock_in);
    n_reset_in = 1'b1;
    wait_ticks(4);
    n_checks++;
    if (v_q.size() !== 0 || busy_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_abort: strobes=%0d busy=%b want 0,0", v_q.size(), busy_out);
    end
    send_frame(8'hC3, 8, 1'b1);
    wait_ticks(4);
    n_checks++;
    if (v_q.size() !== 1 || data_out !== 8'hC3) begin
      n_fail++; $display("FAIL reset_mid_recover: count=%0d data=%h want 1,c3", v_q.size(), data_out);
    end
  endtask

  task automatic test_seven_bits;
    timed_frame(8'h5A, 7, 1'b1);
    n_checks++;
    if (fe7_cnt !== 0) begin n_fail++; $display("FAIL seven_no_ferr: fe pulses=%0d want 0", fe7_cnt); end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_false_start;
    test_framing_error;
    test_back_to_back;
    test_fast_ticks;
    test_reset_mid_frame;
    test_seven_bits;
    n_checks++;
    if (both_cnt !== 0) begin n_fail++; $display("FAIL strobes_exclusive: overlap cycles=%0d want 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
